toeplitz_hash: RTL and testbench
================================

Name: toeplitz_hash

Overview:
- Streaming Toeplitz-matrix hasher for privacy amplification.
- Consumes the seed vectors `row0` (N bits) and `col0` (L bits) produced by the seed-loading stage directly upstream.
- Consumes the raw key as N-bit blocks delivered in BS-bit beats.
- Produces one L-bit hash h = T·x over GF(2) per block, where T is the L×N Toeplitz matrix defined by the seeds.

Parameters:
- BS, 64, beat width in bits; N must be a multiple of BS.
- N, 256, input block length in bits (Toeplitz columns).
- L, 128, hash length in bits (Toeplitz rows).
- XSZ, N/BS, beats per block (derived, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  synchronous active-low reset.
- row0  input  N  first-row seed; bit N-j = T[0][j] for j=1..N-1; bit 0 ignored (corner element lives in col0).
- col0  input  L  first-column seed; bit L-1-i = T[i][0].
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  BS  key beat; bit BS-1 is the earliest key bit x_j.
- out_valid  output  1  hash available.
- out_ready  input  1  hash consumed when out_valid & out_ready.
- out_hash  output  L  bit L-1-i = h_i.
- beat_idx  output  $clog2(XSZ+1)  beats accepted in the current block (debug/status).

Behaviour:
- Reset (rstn low at a clock edge):
  - State goes to ACC; in_ready=1, out_valid=0, out_hash=0, beat_idx=0.
  - Accumulator, window W and row shifter R are all cleared.
  - Reset overrides any handshake in the same cycle. Reset mid-block discards the partial block.
- Internal registers:
  - W (L bits) holds the current Toeplitz column.
  - R (N bits) holds the remaining row elements.
  - A (L bits) is the accumulator.
- Per key bit x (serial definition; BS bits are unrolled combinationally per beat):
  - A ^= x ? W : 0
  - W = {R[N-1], W[L-1:1]}
  - R = R << 1
- Seed sampling:
  - On the first beat of a block (beat_idx==0), the beat is processed with W=col0, R=row0, A=0 taken directly from the ports.
  - row0/col0 changes after beat 0 have no effect until the next block.
- State ACC:
  - in_ready=1, out_valid=0.
  - Each accepted beat updates A/W/R and increments beat_idx.
  - If the accepted beat is beat XSZ-1: out_hash <= final A, beat_idx <= 0, next state OUT.
  - in_valid low: no state change (bubbles allowed anywhere in a block).
- State OUT:
  - in_ready=0, out_valid=1; out_hash held stable.
  - On out_valid & out_ready: next state ACC.
  - out_hash keeps its value after the handshake until the next block completes.
- Latency and throughput:
  - out_valid rises the cycle after the last beat is accepted.
  - Minimum block period is XSZ+1 cycles (the OUT handshake costs one cycle; no input accepted in OUT).
- Arithmetic: all XOR/AND over GF(2); no carries. The BS-step unroll must equal BS applications of the serial rule.
- XSZ==1: every accepted beat goes directly ACC→OUT.
- Elaboration checks:
  - N%BS != 0 is an elaboration error.
  - L<1 or BS<1 is an elaboration error.

Test Plan (BS=4, N=8, L=4 unless stated):
- Identity seeds: col0=4'b1000, row0=8'h00; beats 4'hA, 4'h5 → out_valid the cycle after beat 2; out_hash=4'hA.
- All-ones seeds: col0=4'hF, row0=8'hFF; beats 4'h1, 4'h0 → out_hash=4'hF; beats 4'h3, 4'h0 → 4'h0 (parity rows).
- Shift check: col0=4'b1000, row0=8'b1000_0000 (T[0][1]=1); beats 4'h4, 4'h0 → h_0=x_1=1, h_1=x_1=1 → out_hash=4'b1100.
- Backpressure: hold out_ready=0 for 5 cycles after completion → out_valid=1, out_hash constant, in_ready=0 throughout; release → in_ready=1 next cycle.
- Bubbles and seed freeze: insert 3 idle cycles between beats and change col0 to 4'h0 after beat 1 → hash equals the no-bubble, unchanged-seed result.
- Reset mid-block: accept 1 beat, pulse rstn low 1 cycle → out_valid=0, beat_idx=0; the next 2 beats yield the hash of those beats alone. Random regression against a software GF(2) model at default parameters, 1000 blocks.

Source files
------------

// File: rtl/toeplitz_hash_if.sv
// Beat-in / hash-out handshake bundle for the Toeplitz hasher.
interface toeplitz_hash_if #(
    parameter int BS = 64,
    parameter int L  = 128
) ();
    logic          in_valid;
    logic          in_ready;
    logic [BS-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [L-1:0]  out_hash;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_hash
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_hash
    );
endinterface

// File: rtl/toeplitz_hash.sv
// Streaming Toeplitz hasher: h = T*x over GF(2), one L-bit hash per N-bit block.
// Each BS-bit beat is folded in combinationally, earliest key bit (MSB) first.
module toeplitz_hash #(
    parameter int BS = 64,
    parameter int N  = 256,
    parameter int L  = 128
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N-1:0]                 row0,
    input  logic [L-1:0]                 col0,
    toeplitz_hash_if.slave               bus,
    output logic [$clog2(N/BS+1)-1:0]    beat_idx
);
    localparam int XSZ = N / BS;
    localparam int BW  = $clog2(XSZ + 1);

    if (N % BS != 0) begin : g_bad_block
        $error("toeplitz_hash: N must be a multiple of BS");
    end
    if (L < 1 || BS < 1) begin : g_bad_dims
        $error("toeplitz_hash: L and BS must be at least 1");
    end

    typedef enum logic {S_ACC, S_OUT} state_e;

    state_e        state_q, state_d;
    logic [L-1:0]  a_q, a_d, w_q, w_d, hash_q, hash_d;
    logic [N-1:0]  r_q, r_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [L-1:0]  a_s, w_s;
    logic [N-1:0]  r_s;
    logic          first_beat, last_beat;

    assign first_beat = (beat_q == '0);
    assign last_beat  = (beat_q == BW'(XSZ - 1));

    // Seeds are taken straight from the ports on beat 0 so later seed changes cannot leak in.
    always_comb begin
        a_s = first_beat ? '0   : a_q;
        w_s = first_beat ? col0 : w_q;
        r_s = first_beat ? row0 : r_q;
        for (int k = BS - 1; k >= 0; k--) begin
            if (bus.in_data[k]) a_s = a_s ^ w_s;
            w_s      = w_s >> 1;
            w_s[L-1] = r_s[N-1];
            r_s      = r_s << 1;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        w_d     = w_q;
        r_d     = r_q;
        beat_d  = beat_q;
        hash_d  = hash_q;
        case (state_q)
            S_ACC: begin
                if (bus.in_valid) begin
                    a_d = a_s;
                    w_d = w_s;
                    r_d = r_s;
                    if (last_beat) begin
                        hash_d  = a_s;
                        beat_d  = '0;
                        state_d = S_OUT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) state_d = S_ACC;
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_ACC;
            a_q     <= '0;
            w_q     <= '0;
            r_q     <= '0;
            beat_q  <= '0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            w_q     <= w_d;
            r_q     <= r_d;
            beat_q  <= beat_d;
            hash_q  <= hash_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_hash  = hash_q;
    assign beat_idx      = beat_q;
endmodule

// File: tb/tb_toeplitz_hash.sv
// Directed checks on a BS=4/N=8/L=4 hasher plus a random regression of the default-size hasher.
module tb_toeplitz_hash;
    localparam int SBS = 4, SN = 8, SL = 4;
    localparam int BBS = 64, BN = 256, BL = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [SN-1:0] row0;
    logic [SL-1:0] col0;
    logic [1:0]    beat_idx;
    logic [BN-1:0] brow0;
    logic [BL-1:0] bcol0;
    logic [2:0]    bbeat_idx;
    int            checks = 0;
    int            errors = 0;

    toeplitz_hash_if #(.BS(SBS), .L(SL)) sb ();
    toeplitz_hash_if #(.BS(BBS), .L(BL)) bb ();

    toeplitz_hash #(.BS(SBS), .N(SN), .L(SL)) dut (
        .clk(clk), .rstn(rstn), .row0(row0), .col0(col0), .bus(sb.slave), .beat_idx(beat_idx)
    );

    toeplitz_hash dut_big (
        .clk(clk), .rstn(rstn), .row0(brow0), .col0(bcol0), .bus(bb.slave), .beat_idx(bbeat_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [SBS-1:0] d);
        sb.in_valid = 1'b1;
        sb.in_data  = d;
        tick();
        sb.in_valid = 1'b0;
        sb.in_data  = '0;
    endtask

    task automatic consume();
        sb.out_ready = 1'b1;
        tick();
        sb.out_ready = 1'b0;
    endtask

    // Direct matrix-definition model: T[i][j] from col0 when i>=j, else from row0.
    function automatic logic [BL-1:0] ref_hash(input logic [BN-1:0] r, input logic [BL-1:0] c,
                                               input logic [BN-1:0] x);
        logic [BL-1:0] h;
        logic          acc, t;
        h = '0;
        for (int i = 0; i < BL; i++) begin
            acc = 1'b0;
            for (int j = 0; j < BN; j++) begin
                if (i >= j) t = c[BL-1-(i-j)];
                else        t = r[BN-(j-i)];
                acc = acc ^ (t & x[BN-1-j]);
            end
            h[BL-1-i] = acc;
        end
        return h;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        checks++; if (sb.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", sb.in_ready); end
        checks++; if (sb.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", sb.out_valid); end
        checks++; if (sb.out_hash !== 4'h0) begin errors++; $display("FAIL reset_out_hash got %h want 0", sb.out_hash); end
        checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL reset_beat_idx got %0d want 0", beat_idx); end
        checks++; if (bb.in_ready !== 1'b1 || bb.out_valid !== 1'b0 || bbeat_idx !== 3'd0) begin
            errors++; $display("FAIL reset_big got rdy=%b vld=%b idx=%0d want 1 0 0", bb.in_ready, bb.out_valid, bbeat_idx);
        end
    endtask

    task automatic test_identity();
        col0 = 4'b1000; row0 = 8'h00;
        beat(4'hA);
        checks++; if (beat_idx !== 2'd1) begin errors++; $display("FAIL ident_idx1 got %0d want 1", beat_idx); end
        checks++; if (sb.out_valid !== 1'b0) begin errors++; $display("FAIL ident_early_valid got %b want 0", sb.out_valid); end
        beat(4'h5);
        checks++; if (sb.out_valid !== 1'b1) begin errors++; $display("FAIL ident_valid got %b want 1", sb.out_valid); end
        checks++; if (sb.in_ready !== 1'b0) begin errors++; $display("FAIL ident_in_ready got %b want 0", sb.in_ready); end
        checks++; if (sb.out_hash !== 4'hA) begin errors++; $display("FAIL ident_hash got %h want a", sb.out_hash); end
        checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL ident_idx_wrap got %0d want 0", beat_idx); end
        consume();
        checks++; if (sb.out_valid !== 1'b0 || sb.in_ready !== 1'b1) begin
            errors++; $display("FAIL ident_after_consume got vld=%b rdy=%b want 0 1", sb.out_valid, sb.in_ready);
        end
    endtask

    task automatic test_all_ones();
        col0 = 4'hF; row0 = 8'hFF;
        beat(4'h1); beat(4'h0);
        checks++; if (sb.out_hash !== 4'hF) begin errors++; $display("FAIL ones_odd got %h want f", sb.out_hash); end
        consume();
        beat(4'h3); beat(4'h0);
        checks++; if (sb.out_hash !== 4'h0) begin errors++; $display("FAIL ones_even got %h want 0", sb.out_hash); end
        consume();
    endtask

    task automatic test_shift();
        col0 = 4'b1000; row0 = 8'b1000_0000;
        beat(4'h4); beat(4'h0);
        checks++; if (sb.out_hash !== 4'hC) begin errors++; $display("FAIL shift_hash got %h want c", sb.out_hash); end
        consume();
    endtask

    task automatic test_backpressure();
        col0 = 4'b1000; row0 = 8'h00;
        beat(4'h3); beat(4'hC);
        sb.in_valid = 1'b1;
        sb.in_data  = 4'hF;
        for (int c = 0; c < 5; c++) begin
            checks++; if (sb.out_valid !== 1'b1 || sb.in_ready !== 1'b0 || sb.out_hash !== 4'h3 || beat_idx !== 2'd0) begin
                errors++; $display("FAIL bp_hold cyc %0d got vld=%b rdy=%b hash=%h idx=%0d want 1 0 3 0",
                                   c, sb.out_valid, sb.in_ready, sb.out_hash, beat_idx);
            end
            tick();
        end
        sb.in_valid = 1'b0;
        consume();
        checks++; if (sb.in_ready !== 1'b1 || sb.out_valid !== 1'b0 || sb.out_hash !== 4'h3) begin
            errors++; $display("FAIL bp_release got rdy=%b vld=%b hash=%h want 1 0 3", sb.in_ready, sb.out_valid, sb.out_hash);
        end
    endtask

    task automatic test_bubbles();
        col0 = 4'b1000; row0 = 8'b1000_0000;
        beat(4'h4);
        col0 = 4'h0; row0 = 8'h00;
        repeat (3) tick();
        checks++; if (beat_idx !== 2'd1 || sb.out_valid !== 1'b0) begin
            errors++; $display("FAIL bubble_idle got idx=%0d vld=%b want 1 0", beat_idx, sb.out_valid);
        end
        beat(4'h8);
        checks++; if (sb.out_valid !== 1'b1 || sb.out_hash !== 4'hD) begin
            errors++; $display("FAIL bubble_hash got vld=%b hash=%h want 1 d", sb.out_valid, sb.out_hash);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        col0 = 4'b1000; row0 = 8'h00;
        beat(4'hA);
        checks++; if (beat_idx !== 2'd1) begin errors++; $display("FAIL rmid_idx got %0d want 1", beat_idx); end
        rstn = 1'b0;
        sb.in_valid = 1'b1;
        sb.in_data  = 4'hF;
        tick();
        rstn = 1'b1;
        sb.in_valid = 1'b0;
        checks++; if (sb.out_valid !== 1'b0 || beat_idx !== 2'd0 || sb.in_ready !== 1'b1 || sb.out_hash !== 4'h0) begin
            errors++; $display("FAIL rmid_after got vld=%b idx=%0d rdy=%b hash=%h want 0 0 1 0",
                               sb.out_valid, beat_idx, sb.in_ready, sb.out_hash);
        end
        beat(4'h5);
        checks++; if (sb.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_partial got vld=%b want 0", sb.out_valid); end
        beat(4'h6);
        checks++; if (sb.out_valid !== 1'b1 || sb.out_hash !== 4'h5) begin
            errors++; $display("FAIL rmid_hash got vld=%b hash=%h want 1 5", sb.out_valid, sb.out_hash);
        end
        consume();
    endtask

    task automatic test_random();
        logic [BN-1:0] key;
        logic [BL-1:0] exp_h;
        for (int blk = 0; blk < 1000; blk++) begin
            for (int w = 0; w < BN / 32; w++) brow0[w*32 +: 32] = $urandom();
            for (int w = 0; w < BL / 32; w++) bcol0[w*32 +: 32] = $urandom();
            for (int w = 0; w < BN / 32; w++) key[w*32 +: 32] = $urandom();
            exp_h = ref_hash(brow0, bcol0, key);
            checks++; if (bb.in_ready !== 1'b1) begin errors++; $display("FAIL rand_ready blk %0d got %b want 1", blk, bb.in_ready); end
            for (int b = 0; b < BN / BBS; b++) begin
                if ($urandom_range(0, 3) == 0) tick();
                bb.in_valid = 1'b1;
                bb.in_data  = key[BN-1-b*BBS -: BBS];
                tick();
                bb.in_valid = 1'b0;
                if (b == 0 && blk % 2 == 1) begin
                    brow0 = ~brow0;
                    bcol0 = ~bcol0;
                end
            end
            checks++; if (bb.out_valid !== 1'b1 || bb.out_hash !== exp_h) begin
                errors++; $display("FAIL rand_hash blk %0d got vld=%b hash=%h want 1 %h", blk, bb.out_valid, bb.out_hash, exp_h);
            end
            repeat ($urandom_range(0, 2)) tick();
            bb.out_ready = 1'b1;
            tick();
            bb.out_ready = 1'b0;
        end
    endtask

    initial begin
        rstn = 1'b0;
        row0 = '0; col0 = '0; brow0 = '0; bcol0 = '0;
        sb.in_valid = 1'b0; sb.in_data = '0; sb.out_ready = 1'b0;
        bb.in_valid = 1'b0; bb.in_data = '0; bb.out_ready = 1'b0;
        test_reset();
        test_identity();
        test_all_ones();
        test_shift();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
